// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall insertion, memory-wait freeze,
// branch-redirect flush, stall performance counter and sticky memory-timeout flag.
module hazard_ctrl #(
    parameter int unsigned RF_SIZE  = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         id_opcode_i,
    input  logic [RF_SIZE-1:0] id_rs1_i,
    input  logic [RF_SIZE-1:0] id_rs2_i,
    input  logic [RF_SIZE-1:0] ex_rd_i,
    input  logic               ex_mem_re_i,
    input  logic               mem_req_i,
    input  logic               mem_ready_i,
    input  logic               redirect_i,
    output logic               if_en_o,
    output logic               id_en_o,
    output logic               id_bubble_o,
    output logic               ex_en_o,
    output logic               mem_en_o,
    output logic               flush_if_o,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic               mem_timeout_o
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StLuStall = 2'b01,
        StMemWait = 2'b10,
        StBad     = 2'b11
    } state_e;

    localparam int unsigned RemW = 4;
    localparam logic [RemW-1:0] RemInit    = RemW'(LOAD_LAT - 1);
    localparam logic [15:0]     TimeoutVal = 16'(TIMEOUT);
    localparam bit              MultiLat   = (LOAD_LAT > 1);

    state_e            state_q, state_d;
    state_e            eff_state;
    logic [RemW-1:0]   rem_q, rem_d;
    logic [15:0]       wait_q, wait_d;
    logic              stall_act_q, stall_act_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic rs1_used, rs2_used;
    logic hazard, freeze;
    logic if_en, id_en, id_bubble, ex_en, mem_en, flush_if;

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (id_opcode_i)
            7'b0110011, 7'b0100011: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            7'b0010011, 7'b0000011: rs1_used = 1'b1;
            default: ;
        endcase
    end

    assign hazard = ex_mem_re_i & (ex_rd_i != '0) &
                    ((rs1_used & (ex_rd_i == id_rs1_i)) | (rs2_used & (ex_rd_i == id_rs2_i)));
    assign freeze = mem_req_i & ~mem_ready_i;

    // MEM_WAIT behaves as whatever it interrupted once the memory answers.
    always_comb begin
        case (state_q)
            StLuStall: eff_state = StLuStall;
            StMemWait: eff_state = stall_act_q ? StLuStall : StRun;
            default:   eff_state = StRun;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        wait_d      = 16'd0;
        stall_act_d = 1'b0;
        timeout_d   = timeout_q;
        if_en       = 1'b1;
        id_en       = 1'b1;
        ex_en       = 1'b1;
        mem_en      = 1'b1;
        id_bubble   = 1'b0;
        flush_if    = 1'b0;

        if (freeze) begin
            if_en       = 1'b0;
            id_en       = 1'b0;
            ex_en       = 1'b0;
            mem_en      = 1'b0;
            state_d     = StMemWait;
            stall_act_d = (eff_state == StLuStall);
            wait_d      = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
            if (wait_d >= TimeoutVal) begin
                timeout_d = 1'b1;
            end
        end else if (redirect_i) begin
            flush_if  = 1'b1;
            id_bubble = 1'b1;
            rem_d     = '0;
            state_d   = StRun;
        end else if (eff_state == StLuStall) begin
            if_en     = 1'b0;
            id_bubble = 1'b1;
            if (rem_q <= 4'd1) begin
                rem_d   = '0;
                state_d = StRun;
            end else begin
                rem_d   = rem_q - 4'd1;
                state_d = StLuStall;
            end
        end else if (hazard) begin
            if_en     = 1'b0;
            id_bubble = 1'b1;
            rem_d     = RemInit;
            state_d   = MultiLat ? StLuStall : StRun;
        end else begin
            rem_d   = '0;
            state_d = StRun;
        end
    end

    assign cnt_d = if_en ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            rem_q       <= '0;
            wait_q      <= 16'd0;
            stall_act_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            wait_q      <= wait_d;
            stall_act_q <= stall_act_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    // Nothing is allowed to advance while reset is held.
    assign if_en_o       = if_en & ~rst;
    assign id_en_o       = id_en & ~rst;
    assign ex_en_o       = ex_en & ~rst;
    assign mem_en_o      = mem_en & ~rst;
    assign id_bubble_o   = id_bubble & ~rst;
    assign flush_if_o    = flush_if & ~rst;
    assign state_o       = state_q;
    assign stall_cnt_o   = cnt_q;
    assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3) share stimulus
// and are checked against an owed-bubble reference model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_re, mem_req, mem_ready, redirect;

    logic        a_if_en, a_id_en, a_bub, a_ex_en, a_mem_en, a_flush, a_tmo;
    logic [1:0]  a_state;
    logic [31:0] a_cnt;
    logic        b_if_en, b_id_en, b_bub, b_ex_en, b_mem_en, b_flush, b_tmo;
    logic [1:0]  b_state;
    logic [5:0]  b_cnt;

    hazard_ctrl #(.RF_SIZE(5), .LOAD_LAT(1), .TIMEOUT(3), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .id_opcode_i(id_opcode), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_rd_i(ex_rd), .ex_mem_re_i(ex_mem_re), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .redirect_i(redirect), .if_en_o(a_if_en), .id_en_o(a_id_en), .id_bubble_o(a_bub),
        .ex_en_o(a_ex_en), .mem_en_o(a_mem_en), .flush_if_o(a_flush), .state_o(a_state),
        .stall_cnt_o(a_cnt), .mem_timeout_o(a_tmo)
    );

    hazard_ctrl #(.RF_SIZE(5), .LOAD_LAT(3), .TIMEOUT(6), .CNT_W(6)) u_dut_b (
        .clk(clk), .rst(rst), .id_opcode_i(id_opcode), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_rd_i(ex_rd), .ex_mem_re_i(ex_mem_re), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .redirect_i(redirect), .if_en_o(b_if_en), .id_en_o(b_id_en), .id_bubble_o(b_bub),
        .ex_en_o(b_ex_en), .mem_en_o(b_mem_en), .flush_if_o(b_flush), .state_o(b_state),
        .stall_cnt_o(b_cnt), .mem_timeout_o(b_tmo)
    );

    typedef struct packed {
        logic        if_en;
        logic        id_en;
        logic        id_bubble;
        logic        ex_en;
        logic        mem_en;
        logic        flush_if;
        logic [1:0]  state;
        logic [31:0] stall_cnt;
        logic        mem_timeout;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
    } exp_t;

    typedef struct {
        int              pending;
        int              wait_len;
        bit              tmo;
        longint unsigned cnt;
        logic [1:0]      st;
    } model_t;

    exp_t   sb[$];
    model_t ma, mb;
    int     checks = 0;
    int     passes = 0;
    obs_t   obs_a, obs_b;

    logic [6:0] ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b1101111, 7'b0110111};
    localparam logic [6:0] OpAdd = 7'b0110011, OpAddi = 7'b0010011, OpLui = 7'b0110111;

    always_comb begin
        obs_a = '{a_if_en, a_id_en, a_bub, a_ex_en, a_mem_en, a_flush, a_state, a_cnt, a_tmo};
        obs_b = '{b_if_en, b_id_en, b_bub, b_ex_en, b_mem_en, b_flush, b_state,
                  {26'd0, b_cnt}, b_tmo};
    end

    function automatic bit uses_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011};
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011};
    endfunction

    // One cycle of the reference: pending counts bubbles still owed to the current load.
    task automatic model_step(inout model_t m, input int lat, input int tmo_lim, input int cw,
                              output obs_t o);
        bit haz;
        o = '0;
        if (rst) begin
            m.pending = 0; m.wait_len = 0; m.tmo = 0; m.cnt = 0; m.st = 2'b00;
        end else begin
            o.state       = m.st;
            o.stall_cnt   = 32'(m.cnt);
            o.mem_timeout = m.tmo;
            haz = ex_mem_re && (ex_rd != 0) &&
                  ((uses_rs1(id_opcode) && ex_rd == id_rs1) ||
                   (uses_rs2(id_opcode) && ex_rd == id_rs2));
            if (mem_req && !mem_ready) begin
                m.wait_len = (m.wait_len < 65535) ? m.wait_len + 1 : 65535;
                if (m.wait_len >= tmo_lim) m.tmo = 1;
                m.st = 2'b10;
            end else begin
                m.wait_len = 0;
                o.id_en = 1; o.ex_en = 1; o.mem_en = 1;
                if (redirect) begin
                    o.if_en = 1; o.flush_if = 1; o.id_bubble = 1;
                    m.pending = 0;
                    m.st = 2'b00;
                end else if (m.pending > 0) begin
                    o.id_bubble = 1;
                    m.pending = m.pending - 1;
                    m.st = (m.pending > 0) ? 2'b01 : 2'b00;
                end else if (haz) begin
                    o.id_bubble = 1;
                    m.pending = lat - 1;
                    m.st = (m.pending > 0) ? 2'b01 : 2'b00;
                end else begin
                    o.if_en = 1;
                    m.st = 2'b00;
                end
            end
            if (!o.if_en) m.cnt = (m.cnt + 1) % (64'd1 << cw);
        end
    endtask

    task automatic drive(input bit r, input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] rd, input bit re, input bit mq, input bit mr,
                         input bit rdr);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_opcode = op; id_rs1 = s1; id_rs2 = s2; ex_rd = rd;
        ex_mem_re = re; mem_req = mq; mem_ready = mr; redirect = rdr;
        model_step(ma, 1, 3, 32, e.a);
        model_step(mb, 3, 6, 6, e.b);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, OpLui, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cmp(input string tag, input obs_t act, input obs_t exp);
        chk({tag, ".if_en"}, 32'(act.if_en), 32'(exp.if_en));
        chk({tag, ".id_en"}, 32'(act.id_en), 32'(exp.id_en));
        chk({tag, ".id_bubble"}, 32'(act.id_bubble), 32'(exp.id_bubble));
        chk({tag, ".ex_en"}, 32'(act.ex_en), 32'(exp.ex_en));
        chk({tag, ".mem_en"}, 32'(act.mem_en), 32'(exp.mem_en));
        chk({tag, ".flush_if"}, 32'(act.flush_if), 32'(exp.flush_if));
        chk({tag, ".state"}, 32'(act.state), 32'(exp.state));
        chk({tag, ".stall_cnt"}, act.stall_cnt, exp.stall_cnt);
        chk({tag, ".mem_timeout"}, 32'(act.mem_timeout), 32'(exp.mem_timeout));
    endtask

    // Monitor: outputs are combinational every cycle, so each negedge consumes one entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("A", obs_a, e.a);
                cmp("B", obs_b, e.b);
            end
        end
    end

    initial begin
        int frz_left;
        bit mq, mr;
        rst = 1; id_opcode = OpLui; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        ex_mem_re = 0; mem_req = 0; mem_ready = 1; redirect = 0;
        ma = '{0, 0, 0, 0, 2'b00};
        mb = '{0, 0, 0, 0, 2'b00};

        for (int i = 0; i < 3; i++) drive(1, OpLui, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        idle(2);

        // Load-use: lw x5 in EX, add x?,x5 in ID
        drive(0, OpAdd, 5'd5, 5'd1, 5'd5, 1, 0, 1, 0);
        idle(4);

        // No false hazard: rd=0, and addi whose rs2 field matches
        drive(0, OpAdd, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0);
        drive(0, OpAddi, 5'd1, 5'd7, 5'd7, 1, 0, 1, 0);
        idle(1);

        // Memory freeze for 4 cycles then completion
        for (int i = 0; i < 4; i++) drive(0, OpLui, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        drive(0, OpLui, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);
        idle(2);

        // Redirect in the second stall cycle
        drive(0, OpAdd, 5'd3, 5'd2, 5'd3, 1, 0, 1, 0);
        drive(0, OpAdd, 5'd3, 5'd2, 5'd0, 0, 0, 1, 1);
        idle(3);

        // Freeze for 2 cycles right after the first bubble
        drive(0, OpAdd, 5'd2, 5'd4, 5'd4, 1, 0, 1, 0);
        drive(0, OpAdd, 5'd2, 5'd4, 5'd0, 0, 1, 0, 0);
        drive(0, OpAdd, 5'd2, 5'd4, 5'd0, 0, 1, 0, 0);
        idle(4);

        // Freeze and redirect together, then the held redirect alone
        drive(0, OpLui, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
        drive(0, OpLui, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
        drive(0, OpLui, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
        idle(1);

        // Long wait (B times out), then reset mid-wait
        for (int i = 0; i < 8; i++) drive(0, OpLui, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        drive(1, OpLui, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        drive(1, OpLui, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        idle(2);
        drive(0, OpAdd, 5'd6, 5'd6, 5'd6, 1, 0, 1, 0);
        idle(3);

        frz_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (frz_left == 0 && $urandom_range(0, 19) == 0) frz_left = $urandom_range(1, 8);
            if (frz_left > 0) begin
                mq = 1; mr = 0; frz_left--;
            end else begin
                mq = ($urandom_range(0, 3) == 0);
                mr = ($urandom_range(0, 3) != 0);
            end
            drive(($urandom_range(0, 499) == 0), ops[$urandom_range(0, 6)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)), mq, mr, ($urandom_range(0, 9) == 0));
        end

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
